// File: rtl/apb_requester.sv
// APB3 initiator: turns a valid/ready command stream into setup/access transfers and
// returns read data on a valid/ready response channel. Optional access timeout: APB_TIMEOUT_EN.
module apb_requester #(
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [7:0]        PWDATA,
  input  logic [7:0]        PRDATA,
  input  logic              PREADY
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // SETUP  | APB setup phase (PSEL=1, PENABLE=0)
  // ACCESS | APB access phase, held while PREADY=0
  // RESP   | response presented until rsp_ready
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  state_t state, state_nxt;
  logic   timeout_hit;
  logic   access_done;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be in 1..255");
  end

  assign access_done = (state == ST_ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // The limit is checked in the cycle after the last counted wait, so PREADY there still wins.
  assign timeout_hit = (state == ST_ACCESS) && !PREADY && (wait_cnt == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= 8'd0;
    end else if ((state == ST_ACCESS) && !PREADY && !timeout_hit) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_err <= 1'b0;
    end else if (access_done) begin
      rsp_err <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (access_done || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/bus strobes are registered from the next state so they are glitch-free.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_ready <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == ST_IDLE);
      PSEL      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
      PENABLE   <= (state_nxt == ST_ACCESS);
      rsp_valid <= (state_nxt == ST_RESP);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= 8'd0;
      rsp_rdata <= 8'd0;
    end else begin
      if ((state == ST_IDLE) && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      if (access_done) begin
        rsp_rdata <= PWRITE ? 8'd0 : PRDATA;
      end else if (timeout_hit) begin
        rsp_rdata <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: vector table, hand-written corner sequences
// and randomized transfers against a transaction-level expectation model.
module tb_apb_requester;
  localparam int ADDR_W = 5;
  localparam int TO     = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              PCLK, PRESET;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [7:0]        rsp_rdata;
  logic              PSEL, PENABLE, PWRITE, PREADY;
  logic [ADDR_W-1:0] PADDR;
  logic [7:0]        PWDATA, PRDATA;

  int n_cmp = 0;
  int n_err = 0;

  apb_requester #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: outcome depends only on direction, data and wait count.
  function automatic void model(input logic wr, input logic [7:0] rd, input int waits,
                                output logic [7:0] er, output logic ee, output int eacc);
    bit to;
    to   = TO_EN && (waits > TO);
    eacc = to ? TO + 1 : waits + 1;
    ee   = to;
    er   = (to || wr) ? 8'h00 : rd;
  endfunction

  // One transfer with a completer inserting `waits` wait states and a response stall of `hold` cycles.
  task automatic xfer(input logic wr, input logic [4:0] a, input logic [7:0] wd, input int waits,
                      input logic [7:0] rd, input int hold, input int maxlat,
                      output logic [7:0] r, output logic e, output int lat, output int acc,
                      output bit ok, output bit got);
    int guard;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    PREADY = 1'b0; PRDATA = ~rd; rsp_ready = (hold == 0);
    ok = 1'b1; got = 1'b0; r = 8'h00; e = 1'b0; acc = 0; lat = 0;
    guard = 0;
    while (!cmd_ready && guard < 20) begin step(); guard++; end
    step();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_wdata = ~wd;
    lat = 1;
    if (!(PSEL && !PENABLE)) ok = 1'b0;
    while (!rsp_valid && lat < maxlat) begin
      if (cmd_ready) ok = 1'b0;
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== a || PWRITE !== wr || (wr && PWDATA !== wd)) ok = 1'b0;
        PREADY = (acc > waits);
        PRDATA = PREADY ? rd : ~rd;
      end else begin
        PREADY = 1'b0;
      end
      step();
      lat++;
    end
    PREADY = 1'b0; PRDATA = ~rd;
    if (!rsp_valid) return;
    got = 1'b1; r = rsp_rdata; e = rsp_err;
    if (PSEL || PENABLE || cmd_ready) ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!rsp_valid || rsp_rdata !== r || rsp_err !== e || cmd_ready || PSEL) ok = 1'b0;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (rsp_valid || !cmd_ready) ok = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] a;
    logic [7:0] wd;
    int         waits;
    logic [7:0] rd;
    logic [7:0] exp_r;
    int         exp_lat;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [7:0] r, er;
    logic       e, ee;
    int         lat, acc, eacc;
    bit         ok, got;

    vecs[0] = '{1'b1, 5'h0A, 8'h5C, 0, 8'hC3, 8'h00, 3};
    vecs[1] = '{1'b0, 5'h13, 8'h00, 3, 8'hA7, 8'hA7, 6};
    vecs[2] = '{1'b0, 5'h1F, 8'h00, 0, 8'hFF, 8'hFF, 3};
    vecs[3] = '{1'b1, 5'h00, 8'hFF, 2, 8'h55, 8'h00, 5};
    vecs[4] = '{1'b0, 5'h05, 8'h00, 1, 8'h00, 8'h00, 4};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; PRDATA = 8'h00; PREADY = 1'b0;
    #2;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_outputs", {rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    #10;
    PRESET = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      xfer(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].waits, vecs[i].rd, 0, 60, r, e, lat, acc, ok, got);
      chk($sformatf("vec%0d_got", i), got, 1);
      chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_r);
      chk($sformatf("vec%0d_err", i), e, 0);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_access_cycles", i), acc, vecs[i].waits + 1);
      chk($sformatf("vec%0d_bus", i), ok, 1);
    end

    // Back-to-back with cmd_valid held and a 5-cycle response stall.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h03; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; PREADY = 1'b1; PRDATA = 8'h11;
    step();
    cmd_write = 1'b1; cmd_addr = 5'h1F; cmd_wdata = 8'h99;
    chk("b2b_setup1", {cmd_ready, PSEL, PENABLE}, 3'b010);
    step();
    chk("b2b_access1", {cmd_ready, PSEL, PENABLE, PADDR}, {3'b011, 5'h03});
    step();
    PREADY = 1'b0; PRDATA = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b_stall%0d", i), {rsp_valid, rsp_rdata, rsp_err, cmd_ready, PSEL}, {1'b1, 8'h11, 3'b000});
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    chk("b2b_idle", {cmd_ready, rsp_valid, PSEL}, 3'b100);
    step();
    cmd_valid = 1'b0;
    chk("b2b_setup2", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 5'h1F, 8'h99});
    PREADY = 1'b1;
    step();
    chk("b2b_access2", {PSEL, PENABLE}, 2'b11);
    step();
    PREADY = 1'b0;
    chk("b2b_resp2", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 8'h00, 1'b0});
    step();
    rsp_ready = 1'b0;
    chk("b2b_done", {cmd_ready, rsp_valid}, 2'b10);

    // Asynchronous reset in the middle of an access.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h0C; cmd_wdata = 8'h42; PREADY = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rst_pre_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_async", {PSEL, PENABLE, cmd_ready, rsp_valid}, 4'b0010);
    #2 PRESET = 1'b0;
    step();
    step();
    chk("rst_after", {PSEL, PENABLE, cmd_ready, rsp_valid}, 4'b0010);
    xfer(1'b0, 5'h07, 8'h00, 1, 8'h6D, 0, 60, r, e, lat, acc, ok, got);
    chk("rst_next_read", {got, r, e, ok}, {1'b1, 8'h6D, 1'b0, 1'b1});

`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 5'h09, 8'h00, 1000, 8'h77, 0, 60, r, e, lat, acc, ok, got);
    chk("to_abort", {got, r, e}, {1'b1, 8'h00, 1'b1});
    chk("to_abort_access_cycles", acc, TO + 1);
    chk("to_abort_bus", ok, 1);
    xfer(1'b0, 5'h0B, 8'h00, TO, 8'h3E, 0, 60, r, e, lat, acc, ok, got);
    chk("to_edge_pready_wins", {got, r, e}, {1'b1, 8'h3E, 1'b0});
    chk("to_edge_access_cycles", acc, TO + 1);
`else
    xfer(1'b0, 5'h09, 8'h00, 1000, 8'h77, 0, 102, r, e, lat, acc, ok, got);
    chk("nto_no_response", {got, rsp_valid}, 2'b00);
    chk("nto_still_selected", {PSEL, PENABLE}, 2'b11);
    chk("nto_access_cycles", acc, 100);
    #2 PRESET = 1'b1;
    #3 PRESET = 1'b0;
    step();
    chk("nto_recover", {cmd_ready, PSEL}, 2'b10);
`endif

    for (int i = 0; i < 40; i++) begin
      logic       wr;
      logic [4:0] a;
      logic [7:0] wd, rd;
      int         waits, hold;
      wr    = 1'($urandom);
      a     = 5'($urandom);
      wd    = 8'($urandom);
      rd    = 8'($urandom);
      waits = $urandom_range(0, 6);
      hold  = $urandom_range(0, 3);
      model(wr, rd, waits, er, ee, eacc);
      xfer(wr, a, wd, waits, rd, hold, 60, r, e, lat, acc, ok, got);
      chk($sformatf("rnd%0d_resp", i), {got, r, e}, {1'b1, er, ee});
      chk($sformatf("rnd%0d_timing", i), {lat[15:0], acc[15:0]}, {16'(eacc + 2), 16'(eacc)});
      chk($sformatf("rnd%0d_bus", i), ok, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB initiator. It converts a simple valid/ready command stream into APB3 transfers: setup phase, then access phase with PREADY wait states. It returns the read data or an error through a valid/ready response channel. It is the master-side counterpart to the APB completers (PSEL/PADDR/PENABLE/PWRITE/PWDATA/PRDATA/PREADY bus, 8-bit data) used by the I2C test bridge. It is also used as the bench driver for those completers.

Parameters:
ADDR_W, 5, APB address width (PADDR, cmd_addr).
TIMEOUT_CYCLES, 16, consecutive PREADY-low access cycles before abort (only with APB_TIMEOUT_EN); legal range 1..255.

Ports:
PCLK  input  1  clock; all logic rising-edge.
PRESET  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
cmd_write  input  1  1 = write, 0 = read.
cmd_addr  input  ADDR_W  transfer address.
cmd_wdata  input  8  write data (ignored for reads).
rsp_valid  output  1  response available.
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
rsp_rdata  output  8  read data; 0 for writes and errors.
rsp_err  output  1  1 = transfer aborted by timeout.
PSEL  output  1  APB select.
PENABLE  output  1  APB access phase.
PWRITE  output  1  APB direction.
PADDR  output  ADDR_W  APB address.
PWDATA  output  8  APB write data.
PRDATA  input  8  APB read data.
PREADY  input  1  APB completer ready.

Behaviour:
- Interface decided: one clock, PCLK; reset PRESET is asynchronous, active-high.
- On PRESET the block goes to IDLE. All outputs are 0 except cmd_ready, which is 1. This takes effect immediately, mid-transfer included: PSEL and PENABLE drop without completing the access, and no response is produced for that transfer.
- State machine, registered outputs:
  - IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, cmd_ready=0. Unconditionally go to ACCESS next cycle.
  - ACCESS: PSEL=1, PENABLE=1. Hold every cycle PREADY=0. On PREADY=1:
    - capture PRDATA into rsp_rdata for reads; for writes rsp_rdata=0;
    - rsp_err=0;
    - go to RESP; PSEL and PENABLE are 0 in RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable. On rsp_ready go to IDLE; rsp_valid=0 next cycle.
- PADDR, PWRITE and PWDATA are stable from SETUP through the final ACCESS cycle. In IDLE and RESP they retain their last values; they are not zeroed.
- Latency with zero wait states and rsp_ready tied high:
  - cycle 0: command handshake;
  - cycle 1: SETUP;
  - cycle 2: ACCESS, PREADY=1;
  - cycle 3: rsp_valid=1;
  - cycle 4: cmd_ready=1 again.
- Throughput is one transfer per 4 cycles minimum. No back-to-back SETUP.
- cmd_ready is 1 only in IDLE. Commands offered in any other state stall; they are neither lost nor duplicated.
- PRDATA is sampled only in the ACCESS cycle where PREADY=1.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts and the block goes to RESP with rsp_err=1 and rsp_rdata=0.
  - If PREADY=1 in the same cycle the limit is reached, PREADY wins: normal completion, rsp_err=0.
- Not defined: ACCESS waits indefinitely, no counter is built, and rsp_err is constant 0.

Test Plan:
1. Write addr=5'h0A, data=8'h5C, PREADY tied 1 -> PSEL rises cycle 1, PENABLE cycle 2 with PADDR=0A, PWRITE=1, PWDATA=5C; rsp_valid cycle 3 with rdata=00, err=0.
2. Read addr=5'h13, completer returns PRDATA=8'hA7 after 3 wait states -> ACCESS lasts 4 cycles with PADDR stable; rsp_rdata=A7; rsp_valid 6 cycles after handshake.
3. Back-to-back commands with cmd_valid held high and rsp_ready held low for 5 cycles -> rsp_valid/rdata/err held for the stall; cmd_ready=0 throughout; second transfer SETUP begins 2 cycles after rsp_ready handshake.
4. PRESET asserted during ACCESS of a write -> PSEL=PENABLE=0 in the same cycle (asynchronous); after release cmd_ready=1, rsp_valid=0; next read completes normally.
5. APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_rdata=00; PSEL=0 in RESP.
6. APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY rises on the 5th ACCESS cycle with PRDATA=8'h3E -> err=0, rdata=3E. Without the macro, PREADY held 0 for 100 cycles -> no response, PSEL stays 1.
